cordic_sincos_iter: RTL

Parametrised iterative CORDIC sine/cosine generator: full-turn unsigned angle in, signed sine and cosine out, with start/valid handshake and quadrant folding so all four quadrants are covered. Successor to the first-quadrant, fixed 8-bit CORDIC; sits in the DSP datapath as the shared oscillator/rotation source for NCOs and mixers.

---
 rtl/cordic_pkg.sv | 83 ++++++++
 rtl/cordic_sincos_iter_micro_rot.sv | 38 +++
 rtl/cordic_sincos_iter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and helpers for the iterative CORDIC sine/cosine block.
//   ATAN_TABLE : atan(2^-i) for i = 0..23, 2^32 units per full turn.
//   K_GAIN_32  : CORDIC gain compensation constant K = 0.607252935, scaled by 2^32.
//   cordic_state_e : controller states (IDLE / ITERATE / DONE).
//   atan_slice : rounds a table entry down to a WIDTH-bit phase scale.
//   gain_x0    : rounds K to a 2^WIDTH scale.
//   unfold     : maps a first-quadrant (cos, sin) pair back to the full circle.
package cordic_pkg;

  localparam logic [31:0] ATAN_TABLE [24] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
  };

  localparam logic [31:0] K_GAIN_32 = 32'd2608131496;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ITERATE = 2'd1,
    ST_DONE    = 2'd2
  } cordic_state_e;

  typedef struct packed {
    logic signed [31:0] sin_v;
    logic signed [31:0] cos_v;
  } sincos_t;

  // Rounding right shift of a 2^32-per-turn entry down to 2^width per turn.
  function automatic logic [31:0] atan_slice(input logic [4:0] idx, input int width);
    logic [32:0] acc;
    acc = {1'b0, ATAN_TABLE[idx]} + (33'd1 << (31 - width));
    return 32'(acc >> (32 - width));
  endfunction

  function automatic logic [31:0] gain_x0(input int width);
    logic [32:0] acc;
    acc = {1'b0, K_GAIN_32} + (33'd1 << (31 - width));
    return 32'(acc >> (32 - width));
  endfunction

  // Negation clamped to the symmetric range +/-(2^(width-1)-1) so the most
  // negative code never appears and the result is defined for any input.
  function automatic logic signed [31:0] neg_sat(input logic signed [31:0] v, input int width);
    logic signed [31:0] lim;
    logic signed [31:0] r;
    lim = (32'sd1 <<< (width - 1)) - 32'sd1;
    r   = -v;
    if (r > lim) r = lim;
    if (r < -lim) r = -lim;
    return r;
  endfunction

  function automatic sincos_t unfold(input logic [1:0] quad,
                                     input logic signed [31:0] c,
                                     input logic signed [31:0] s,
                                     input int width);
    sincos_t r;
    case (quad)
      2'd0: begin
        r.cos_v = c;
        r.sin_v = s;
      end
      2'd1: begin
        r.cos_v = neg_sat(s, width);
        r.sin_v = c;
      end
      2'd2: begin
        r.cos_v = neg_sat(c, width);
        r.sin_v = neg_sat(s, width);
      end
      default: begin
        r.cos_v = s;
        r.sin_v = neg_sat(c, width);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_sincos_iter_micro_rot.sv
// cordic_micro_rot: one combinational CORDIC micro-rotation in rotation mode.
//   x_in/y_in  : current vector, signed WIDTH+2 (2 guard LSBs)
//   z_in       : residual angle, signed WIDTH+1
//   shift      : iteration index i
//   atan_in    : atan(2^-i) on the WIDTH-bit phase scale
//   x_out/y_out/z_out : vector and residual after rotating toward z = 0
module cordic_micro_rot #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH+1:0] x_in,
  input  logic signed [WIDTH+1:0] y_in,
  input  logic signed [WIDTH:0]   z_in,
  input  logic        [4:0]       shift,
  input  logic signed [WIDTH:0]   atan_in,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic signed [WIDTH:0]   z_out
);

  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;

  always_comb begin
    x_sh = x_in >>> shift;
    y_sh = y_in >>> shift;
    // Non-negative residual: rotate counter-clockwise (d = +1).
    if (!z_in[WIDTH]) begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_in;
    end else begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_in;
    end
  end

endmodule

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative full-turn CORDIC sine/cosine generator.
//   CLK         : clock, rising edge
//   RESET_PULSE : asynchronous active-low reset
//   START       : request, accepted with ANGLE in IDLE or DONE (ignored in ITERATE)
//   ANGLE       : unsigned phase, full turn = 2^WIDTH
//   SIN/COS     : signed results, 1.0 = 2^(WIDTH-2); held until the next result
//   VALID       : one-cycle strobe while the new SIN/COS are first presented
//   BUSY        : high while iterating
//   DBG_STATE   : controller state (cordic_state_e encoding)
// Build option: define CORDIC_GAIN_COMP_EN to start X at K (unit amplitude);
// otherwise X starts at 1.0 and the outputs carry the CORDIC gain (~1.6468).
//
// Handshake: START is a request level sampled on the rising edge; it is taken
// only when the block is not iterating, and there is no queuing. A result is
// announced by VALID for exactly one cycle, ITER edges after acceptance.
module cordic_sincos_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic                    CLK,
  input  logic                    RESET_PULSE,
  input  logic                    START,
  input  logic        [WIDTH-1:0] ANGLE,
  output logic signed [WIDTH-1:0] SIN,
  output logic signed [WIDTH-1:0] COS,
  output logic                    VALID,
  output logic                    BUSY,
  output logic        [1:0]       DBG_STATE
);

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH+1:0] X_INIT = (WIDTH+2)'(gain_x0(WIDTH));
`else
  localparam logic signed [WIDTH+1:0] X_INIT = {2'b01, {WIDTH{1'b0}}};
`endif

  cordic_state_e           state_q, state_d;
  logic        [1:0]       quad_q, quad_d;
  logic signed [WIDTH+1:0] x_q, x_d;
  logic signed [WIDTH+1:0] y_q, y_d;
  logic signed [WIDTH:0]   z_q, z_d;
  logic        [4:0]       i_q, i_d;
  logic signed [WIDTH-1:0] sin_q, sin_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;

  logic signed [WIDTH:0]   atan_cur;
  logic signed [WIDTH+1:0] x_rot;
  logic signed [WIDTH+1:0] y_rot;
  logic signed [WIDTH:0]   z_rot;
  logic signed [WIDTH-1:0] c_w;
  logic signed [WIDTH-1:0] s_w;
  sincos_t                 fold;

  assign atan_cur = (WIDTH+1)'(atan_slice(i_q, WIDTH));

  cordic_micro_rot #(.WIDTH(WIDTH)) u_rot (
    .x_in    (x_q),
    .y_in    (y_q),
    .z_in    (z_q),
    .shift   (i_q),
    .atan_in (atan_cur),
    .x_out   (x_rot),
    .y_out   (y_rot),
    .z_out   (z_rot)
  );

  // Drop the two guard LSBs (arithmetic shift, truncation) of the final vector.
  assign c_w = x_rot[WIDTH+1:2];
  assign s_w = y_rot[WIDTH+1:2];

  always_comb begin
    fold = unfold(quad_q, 32'(c_w), 32'(s_w), WIDTH);
  end

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    sin_d   = sin_q;
    cos_d   = cos_q;

    case (state_q)
      ST_ITERATE: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + 5'd1;
        if (i_q == 5'(ITER - 1)) begin
          state_d = ST_DONE;
          sin_d   = WIDTH'(fold.sin_v);
          cos_d   = WIDTH'(fold.cos_v);
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        state_d = ST_IDLE;
        if (START) begin
          state_d = ST_ITERATE;
          quad_d  = ANGLE[WIDTH-1:WIDTH-2];
          z_d     = {3'b000, ANGLE[WIDTH-3:0]};
          x_d     = X_INIT;
          y_d     = '0;
          i_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_PULSE) begin
    if (!RESET_PULSE) begin
      state_q <= ST_IDLE;
      quad_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign SIN       = sin_q;
  assign COS       = cos_q;
  assign VALID     = (state_q == ST_DONE);
  assign BUSY      = (state_q == ST_ITERATE);
  assign DBG_STATE = state_q;

endmodule
